// File: rtl/br_stack.sv
// Branch checkpoint stack: one-hot tags for speculative branches, each holding the
// free-list head, ROB tail and the set of older unresolved branches it depends on.
module br_stack #(
    parameter int NUM_BR    = 4,
    parameter int FL_PTR_W  = 5,
    parameter int ROB_PTR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_req_i,
    input  logic [FL_PTR_W-1:0]  alloc_fl_head_i,
    input  logic [ROB_PTR_W-1:0] alloc_rob_tail_i,
    output logic                 alloc_gnt_o,
    output logic [NUM_BR-1:0]    alloc_tag_o,
    output logic                 alloc_stall_o,
    output logic [NUM_BR-1:0]    br_mask_o,
    output logic                 full_o,
    input  logic                 resolve_valid_i,
    input  logic [NUM_BR-1:0]    resolve_tag_i,
    input  logic                 resolve_correct_i,
    output logic                 clr_valid_o,
    output logic [NUM_BR-1:0]    clr_tag_o,
    output logic                 recover_valid_o,
    output logic [NUM_BR-1:0]    squash_mask_o,
    output logic [FL_PTR_W-1:0]  recover_fl_head_o,
    output logic [ROB_PTR_W-1:0] recover_rob_tail_o
);

    logic [NUM_BR-1:0]                busy;
    logic [NUM_BR-1:0][FL_PTR_W-1:0]  fl_q;
    logic [NUM_BR-1:0][ROB_PTR_W-1:0] rob_q;
    logic [NUM_BR-1:0][NUM_BR-1:0]    dep_q;
    logic                             hit;
    logic [NUM_BR-1:0]                free_sel;

    assign br_mask_o = busy;
    assign full_o    = &busy;

    always_comb begin
        hit             = resolve_valid_i & (|(resolve_tag_i & busy));
        clr_valid_o     = hit & resolve_correct_i;
        clr_tag_o       = clr_valid_o ? resolve_tag_i : '0;
        recover_valid_o = hit & ~resolve_correct_i;

        squash_mask_o      = '0;
        recover_fl_head_o  = '0;
        recover_rob_tail_o = '0;
        for (int i = 0; i < NUM_BR; i++) begin
            if (recover_valid_o && busy[i] &&
                (resolve_tag_i[i] || (|(dep_q[i] & resolve_tag_i))))
                squash_mask_o[i] = 1'b1;
            if (recover_valid_o && busy[i] && resolve_tag_i[i]) begin
                recover_fl_head_o  = recover_fl_head_o | fl_q[i];
                recover_rob_tail_o = recover_rob_tail_o | rob_q[i];
            end
        end
    end

    // Grant looks only at registered busy bits, so a slot freed this cycle is
    // not reusable until the next one.
    always_comb begin
        logic found;
        found    = 1'b0;
        free_sel = '0;
        for (int i = 0; i < NUM_BR; i++) begin
            if (!busy[i] && !found) begin
                free_sel[i] = 1'b1;
                found       = 1'b1;
            end
        end
        alloc_gnt_o   = alloc_req_i & ~full_o & ~recover_valid_o;
        alloc_tag_o   = alloc_gnt_o ? free_sel : '0;
        alloc_stall_o = alloc_req_i & ~alloc_gnt_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= '0;
            fl_q  <= '0;
            rob_q <= '0;
            dep_q <= '0;
        end else begin
            for (int i = 0; i < NUM_BR; i++) begin
                if (squash_mask_o[i]) begin
                    busy[i]  <= 1'b0;
                    dep_q[i] <= '0;
                end else begin
                    if (clr_tag_o[i])
                        busy[i] <= 1'b0;
                    dep_q[i] <= dep_q[i] & ~clr_tag_o;
                    if (alloc_tag_o[i]) begin
                        busy[i]  <= 1'b1;
                        fl_q[i]  <= alloc_fl_head_i;
                        rob_q[i] <= alloc_rob_tail_i;
                        dep_q[i] <= busy & ~clr_tag_o;
                    end
                end
            end
        end
    end

endmodule
